// File: rtl/id_ex_if.sv
// id_ex_if: signal bundle between the ID stage and the ID/EX pipeline register.
//   master : ID side / environment. Drives the decoded id_* fields and flush,
//            observes the registered ex_* fields, stall and stall_cnt.
//   slave  : the id_ex_stage register itself.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // ID side
  logic              id_valid;
  logic              id_branch_eq, id_branch_ne;
  logic [2:0]        id_aluop;
  logic              id_memread, id_memwrite, id_memtoreg;
  logic              id_regdst, id_regwrite, id_alusrc, id_jump;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              flush;
  // EX side
  logic              ex_valid;
  logic              ex_branch_eq, ex_branch_ne;
  logic [2:0]        ex_aluop;
  logic              ex_memread, ex_memwrite, ex_memtoreg;
  logic              ex_regdst, ex_regwrite, ex_alusrc, ex_jump;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_branch_eq, id_branch_ne, id_aluop, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_regwrite, id_alusrc, id_jump,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    input  ex_valid, ex_branch_eq, ex_branch_ne, ex_aluop, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_jump,
           ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_branch_eq, id_branch_ne, id_aluop, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_regwrite, id_alusrc, id_jump,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    output ex_valid, ex_branch_eq, ex_branch_ne, ex_aluop, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regdst, ex_regwrite, ex_alusrc, ex_jump,
           ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register.
//   Latches decoded control and operand data for EX (1-cycle latency),
//   detects load-use hazards (combinational stall), inserts bubbles on
//   stall / flush / invalid ID, and forces decoder don't-care controls to 0.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : id_ex_if.slave -- id_* / flush in; ex_*, ex_valid, stall, stall_cnt out
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic     clk,
  input logic     rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic [2:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrc;
    logic       jump;
  } ctrl_t;

  ctrl_t             canon, ex_ctrl;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0]  cnt;
  logic              rt_used, hazard, load_en;

  // Jumps don't use branch/ALU/regdst/memtoreg, stores don't write a register:
  // the decoder leaves those as don't-care, so mask them with explicit ANDs
  // (0 & X = 0) to keep X out of EX.
  always_comb begin
    canon           = '0;
    canon.branch_eq = bus.id_branch_eq & ~bus.id_jump;
    canon.branch_ne = bus.id_branch_ne & ~bus.id_jump;
    canon.aluop     = bus.id_aluop & {3{~bus.id_jump}};
    canon.alusrc    = bus.id_alusrc & ~bus.id_jump;
    canon.regdst    = bus.id_regdst & ~bus.id_jump & ~bus.id_memwrite;
    canon.memtoreg  = bus.id_memtoreg & ~bus.id_jump & ~bus.id_memwrite;
    canon.memread   = bus.id_memread;
    canon.memwrite  = bus.id_memwrite;
    canon.regwrite  = bus.id_regwrite;
    canon.jump      = bus.id_jump;
  end

  // rt is a source operand unless the ALU takes the immediate; stores read rt
  // as the store data even though alusrc=1.
  assign rt_used = ~bus.id_alusrc | bus.id_memwrite;

  // Flush is folded in here so a flushed cycle never counts as a stall.
  assign hazard = ~rst & ex_valid & ex_ctrl.memread & bus.id_valid & ~bus.flush
                & (ex_rt != '0)
                & ((ex_rt == bus.id_rs) | ((ex_rt == bus.id_rt) & rt_used));

  assign load_en = bus.id_valid & ~bus.flush & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      cnt      <= '0;
    end else begin
      // bubble = controls and valid cleared; data fields are don't-care and load regardless
      ex_ctrl  <= load_en ? canon : '0;
      ex_valid <= load_en;
      ex_pc4   <= bus.id_pc4;
      ex_rd1   <= bus.id_rd1;
      ex_rd2   <= bus.id_rd2;
      ex_imm   <= bus.id_imm;
      ex_rs    <= bus.id_rs;
      ex_rt    <= bus.id_rt;
      ex_rd    <= bus.id_rd;
      if (hazard && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_branch_eq = ex_ctrl.branch_eq;
  assign bus.ex_branch_ne = ex_ctrl.branch_ne;
  assign bus.ex_aluop     = ex_ctrl.aluop;
  assign bus.ex_memread   = ex_ctrl.memread;
  assign bus.ex_memwrite  = ex_ctrl.memwrite;
  assign bus.ex_memtoreg  = ex_ctrl.memtoreg;
  assign bus.ex_regdst    = ex_ctrl.regdst;
  assign bus.ex_regwrite  = ex_ctrl.regwrite;
  assign bus.ex_alusrc    = ex_ctrl.alusrc;
  assign bus.ex_jump      = ex_ctrl.jump;
  assign bus.ex_pc4       = ex_pc4;
  assign bus.ex_rd1       = ex_rd1;
  assign bus.ex_rd2       = ex_rd2;
  assign bus.ex_imm       = ex_imm;
  assign bus.ex_rs        = ex_rs;
  assign bus.ex_rt        = ex_rt;
  assign bus.ex_rd        = ex_rd;
  assign bus.stall        = hazard;
  assign bus.stall_cnt    = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  typedef struct packed {
    bit        v;
    bit        beq, bne;
    bit [2:0]  aluop;
    bit        mr, mw, mtr, rdst, rw, asrc, j;
    bit [31:0] pc4, rd1, rd2, imm;
    bit [4:0]  rs, rt, rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ins_t cur, m_ex;
  bit   cur_fl;
  int   m_cnt;
  bit   last_stall;

  id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pack_ctrl(input ins_t i);
    return {i.beq, i.bne, i.aluop, i.mr, i.mw, i.mtr, i.rdst, i.rw, i.asrc, i.j};
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {bus.ex_branch_eq, bus.ex_branch_ne, bus.ex_aluop, bus.ex_memread,
            bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regdst, bus.ex_regwrite,
            bus.ex_alusrc, bus.ex_jump};
  endfunction

  task automatic drive(input ins_t i, input bit fl);
    cur = i; cur_fl = fl;
    bus.id_valid = i.v;       bus.id_branch_eq = i.beq; bus.id_branch_ne = i.bne;
    bus.id_aluop = i.aluop;   bus.id_memread = i.mr;    bus.id_memwrite = i.mw;
    bus.id_memtoreg = i.mtr;  bus.id_regdst = i.rdst;   bus.id_regwrite = i.rw;
    bus.id_alusrc = i.asrc;   bus.id_jump = i.j;
    bus.id_pc4 = i.pc4; bus.id_rd1 = i.rd1; bus.id_rd2 = i.rd2; bus.id_imm = i.imm;
    bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
    bus.flush = fl;
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, {127'd0, bus.ex_valid}, {127'd0, m_ex.v});
    chk({tag, ".ctrl"}, {116'd0, dut_ctrl()}, {116'd0, pack_ctrl(m_ex)});
    chk({tag, ".data"}, {bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm},
                        {m_ex.pc4, m_ex.rd1, m_ex.rd2, m_ex.imm});
    chk({tag, ".regs"}, {113'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd},
                        {113'd0, m_ex.rs, m_ex.rt, m_ex.rd});
    chk({tag, ".cnt"}, {126'd0, bus.stall_cnt}, 128'(m_cnt));
  endtask

  // One clock: stall checked mid-cycle, then the model advances one
  // instruction slot and the registered outputs are checked after the edge.
  task automatic step(input string tag);
    bit   exp_stall, rt_read;
    ins_t nxt;
    @(negedge clk);
    // EX load writes rt; ID instruction reads rs always, rt for R-type and stores
    rt_read   = !cur.asrc || cur.mw;
    exp_stall = m_ex.v && m_ex.mr && cur.v && !cur_fl && m_ex.rt != 0 &&
                (m_ex.rt == cur.rs || (m_ex.rt == cur.rt && rt_read));
    chk({tag, ".stall"}, {127'd0, bus.stall}, {127'd0, exp_stall});
    nxt = cur;
    if (cur_fl || exp_stall || !cur.v) begin
      {nxt.v, nxt.beq, nxt.bne, nxt.aluop, nxt.mr, nxt.mw} = '0;
      {nxt.mtr, nxt.rdst, nxt.rw, nxt.asrc, nxt.j} = '0;
    end else begin
      if (cur.j)  begin nxt.beq = 0; nxt.bne = 0; nxt.aluop = 0; nxt.rdst = 0;
                        nxt.mtr = 0; nxt.asrc = 0; end
      if (cur.mw) begin nxt.rdst = 0; nxt.mtr = 0; end
    end
    if (exp_stall && m_cnt < 3) m_cnt++;
    last_stall = exp_stall;
    @(posedge clk);
    m_ex = nxt;
    #1;
    check_ex(tag);
  endtask

  function automatic ins_t mk(input bit mr, input bit [4:0] rs, input bit [4:0] rt,
                              input bit asrc);
    ins_t i = '0;
    i.v = 1; i.mr = mr; i.rs = rs; i.rt = rt; i.asrc = asrc; i.rw = 1;
    i.mtr = mr; i.aluop = 3'b010; i.rd = 5'd3;
    i.pc4 = $urandom; i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i = ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    i.v  = ($urandom_range(0, 9) < 8);
    i.rs = 5'($urandom_range(0, 3));
    i.rt = 5'($urandom_range(0, 3));
    i.j  = ($urandom_range(0, 7) == 0);
    return i;
  endfunction

  initial begin
    ins_t a;
    int   saved;
    m_ex = '0; m_cnt = 0; last_stall = 0;
    drive('0, 0);
    #1;
    chk("init.stall_in_rst", {127'd0, bus.stall}, 128'd0);
    check_ex("init");
    #12 rst = 1'b0;             // t=13, clear of both edges

    // T2 pass-through
    a = '0; a.v = 1; a.aluop = 3'b101; a.rw = 1; a.rdst = 1; a.rd1 = 5; a.rd2 = 7;
    a.rd = 3; a.rs = 1; a.rt = 2; a.pc4 = 32'h104;
    drive(a, 0);
    step("t2");
    chk("t2.aluop", {125'd0, bus.ex_aluop}, 128'd5);
    chk("t2.rw_valid", {126'd0, bus.ex_regwrite, bus.ex_valid}, 128'd3);
    chk("t2.rd1_rd2_rd", {bus.ex_rd1, bus.ex_rd2, 59'd0, bus.ex_rd},
                          {32'd5, 32'd7, 59'd0, 5'd3});

    // T1 asynchronous reset mid-cycle, no clock edge in between
    #2 rst = 1'b1;
    #1;
    m_ex = '0; m_cnt = 0;
    chk("t1.stall", {127'd0, bus.stall}, 128'd0);
    check_ex("t1");
    #1 rst = 1'b0;

    // T3 load-use: lw rt=8 then add rs=8
    drive(mk(1, 5'd2, 5'd8, 1), 0); step("t3.lw");
    drive(mk(0, 5'd8, 5'd3, 0), 0); step("t3.bubble");
    chk("t3.was_stall", {127'd0, last_stall}, 128'd1);
    chk("t3.bubble_v_rw", {126'd0, bus.ex_valid, bus.ex_regwrite}, 128'd0);
    step("t3.reload");
    chk("t3.add_valid", {127'd0, bus.ex_valid}, 128'd1);
    chk("t3.cnt", {126'd0, bus.stall_cnt}, 128'd1);

    // T4 no false hazard
    drive(mk(1, 5'd1, 5'd0, 1), 0); step("t4.lw0");
    drive(mk(0, 5'd0, 5'd0, 0), 0); step("t4.add0");
    chk("t4.no_stall_r0", {127'd0, last_stall}, 128'd0);
    drive(mk(1, 5'd1, 5'd9, 1), 0); step("t4.lw9");
    drive(mk(0, 5'd4, 5'd9, 1), 0); step("t4.addi");
    chk("t4.no_stall_imm", {127'd0, last_stall}, 128'd0);

    // T5 flush beats hazard
    drive(mk(1, 5'd1, 5'd8, 1), 0); step("t5.lw");
    drive(mk(0, 5'd8, 5'd3, 0), 1); step("t5.flush");
    chk("t5.valid", {127'd0, bus.ex_valid}, 128'd0);
    chk("t5.cnt", {126'd0, bus.stall_cnt}, 128'd1);

    // T6 canonicalise a jump with X on don't-care controls
    a = '0; a.v = 1; a.j = 1; a.pc4 = 32'h200;
    drive(a, 0);
    bus.id_branch_eq = 1'bx; bus.id_branch_ne = 1'bx; bus.id_regdst = 1'bx;
    bus.id_aluop = 3'bxxx; bus.id_memtoreg = 1'bx; bus.id_alusrc = 1'bx;
    step("t6.j");
    chk("t6.j_ctrl", {116'd0, dut_ctrl()}, 128'h001);

    // T6 saturation: four more hazards with a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      drive(mk(1, 5'd1, 5'd8, 1), 0); step("t6.lw");
      drive(mk(0, 5'd5, 5'd8, 0), 0); step("t6.use");
      step("t6.reload");
    end
    chk("t6.sat", {126'd0, bus.stall_cnt}, 128'd3);

    // randomized traffic; upstream holds ID while stalled
    saved = errors;
    for (int n = 0; n < 300; n++) begin
      if (!last_stall) drive(rand_ins(), ($urandom_range(0, 9) == 0));
      else             drive(cur, cur_fl);
      step("rand");
    end
    if (errors != saved) $display("random phase: %0d errors", errors - saved);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
